// File: rtl/alien_ship_if.sv
// Alien ship reader bus: draw coordinates, ship control,
// sprite RAM read port and pixel output to the colour mapper.
interface alien_ship_if #(
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 24
);
  logic               frame_start;
  logic               pixel_valid;
  logic [9:0]         DrawX;
  logic [9:0]         DrawY;
  logic [9:0]         ship_x;
  logic [9:0]         ship_y;
  logic               spawn;
  logic               hit;
  logic [ADDR_W-1:0]  read_address;
  logic [COLOR_W-1:0] ram_data;
  logic               sprite_on;
  logic [COLOR_W-1:0] sprite_rgb;
  logic [1:0]         ship_state;

  modport master (
    output frame_start, pixel_valid,
    output DrawX, DrawY, ship_x, ship_y,
    output spawn, hit, ram_data,
    input  read_address, sprite_on,
    input  sprite_rgb, ship_state
  );

  modport slave (
    input  frame_start, pixel_valid,
    input  DrawX, DrawY, ship_x, ship_y,
    input  spawn, hit, ram_data,
    output read_address, sprite_on,
    output sprite_rgb, ship_state
  );
endinterface

// File: rtl/alien_ship_reader.sv
// Alien ship sprite RAM reader: box test, address gen,
// 3-stage colour-keyed pixel pipeline and visibility FSM.
module alien_ship_reader #(
  parameter int          SPRITE_W     = 55,
  parameter int          SPRITE_H     = 40,
  parameter int          ADDR_W       = 19,
  parameter int          COLOR_W      = 24,
  parameter logic [23:0] KEY_COLOR    = 24'hFF00FF,
  parameter int          BLINK_FRAMES = 8,
  parameter int          BLINK_COUNT  = 4
) (
  input logic         Clk,
  input logic         Reset_n,
  alien_ship_if.slave bus
);
  localparam logic [1:0] HIDDEN = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] BLINK  = 2'd2;
  localparam int FW = $clog2(BLINK_FRAMES);
  localparam int BW = $clog2(2 * BLINK_COUNT);

  logic [9:0]        xl, yl;
  logic [1:0]        state;
  logic [FW-1:0]     frame_cnt;
  logic [BW-1:0]     blink_cnt;
  logic              spawn_pend, hit_pend;
  logic              spawn_evt, hit_evt;
  logic              hit1, hit2;
  logic              visible, in_box, keep;
  logic [10:0]       dx, dy;
  logic [ADDR_W-1:0] addr_next;

  assign dx = {1'b0, bus.DrawX} - {1'b0, xl};
  assign dy = {1'b0, bus.DrawY} - {1'b0, yl};

  assign in_box = bus.pixel_valid
                & ~dx[10] & ~dy[10]
                & (dx < 11'(SPRITE_W))
                & (dy < 11'(SPRITE_H));

  assign addr_next = ADDR_W'(dy) * ADDR_W'(SPRITE_W)
                   + ADDR_W'(dx);

  // events arriving with frame_start are consumed by it
  assign spawn_evt = spawn_pend | bus.spawn;
  assign hit_evt   = hit_pend | bus.hit;

  always_comb begin
    visible = 1'b0;
    unique case (1'b1)
      (state == ACTIVE): visible = 1'b1;
      (state == BLINK):  visible = ~blink_cnt[0];
      default:           visible = 1'b0;
    endcase
  end

  assign keep = hit2 & visible
              & (bus.ram_data != COLOR_W'(KEY_COLOR));

  assign bus.ship_state = state;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      spawn_pend <= 1'b0;
      hit_pend   <= 1'b0;
    end else if (bus.frame_start) begin
      spawn_pend <= 1'b0;
      hit_pend   <= 1'b0;
    end else begin
      spawn_pend <= spawn_evt;
      hit_pend   <= hit_evt;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= HIDDEN;
      frame_cnt <= '0;
      blink_cnt <= '0;
      xl        <= '0;
      yl        <= '0;
    end else if (bus.frame_start) begin
      xl <= bus.ship_x;
      yl <= bus.ship_y;
      unique case (1'b1)
        (state == HIDDEN): begin
          if (spawn_evt) state <= ACTIVE;
        end
        (state == ACTIVE): begin
          if (hit_evt) begin
            state     <= BLINK;
            frame_cnt <= '0;
            blink_cnt <= '0;
          end
        end
        (state == BLINK): begin
          if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
            frame_cnt <= '0;
            if (blink_cnt == BW'(2 * BLINK_COUNT - 1))
              state <= HIDDEN;
            else
              blink_cnt <= blink_cnt + 1'b1;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        default: state <= HIDDEN;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hit1             <= 1'b0;
      hit2             <= 1'b0;
      bus.read_address <= '0;
      bus.sprite_on    <= 1'b0;
      bus.sprite_rgb   <= '0;
    end else begin
      hit1 <= in_box;
      hit2 <= hit1;
      if (in_box) bus.read_address <= addr_next;
      bus.sprite_on  <= keep;
      bus.sprite_rgb <= keep ? bus.ram_data : '0;
    end
  end
endmodule

// File: tb/tb_alien_ship_reader.sv
// Bench for alien_ship_reader: scoreboard of expected
// pixels against a behavioural ship/RAM model.
module tb_alien_ship_reader;
  localparam logic [23:0] KEY = 24'hFF00FF;

  typedef struct {
    bit          on;
    logic [23:0] rgb;
  } exp_t;

  logic Clk;
  logic Reset_n;
  bit   mode;
  int   n_checks;
  int   n_fail;

  exp_t sb[$];
  int   m_state, m_n, m_xl, m_yl, m_addr;
  bit   m_sp, m_ht;

  alien_ship_if #(.ADDR_W(19), .COLOR_W(24)) bus ();

  alien_ship_reader dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [23:0] ram_fn(
    input logic [18:0] a, input bit m);
    if (a == 19'd5) return KEY;
    if (m) return {5'h0A, a};
    return 24'h00FF00;
  endfunction

  always @(posedge Clk)
    bus.ram_data <= ram_fn(bus.read_address, mode);

  function automatic bit m_visible();
    if (m_state == 1) return 1'b1;
    if (m_state == 2) return ((m_n / 8) % 2) == 0;
    return 1'b0;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit fs, input bit pv,
                      input int x, input int y,
                      input bit sp, input bit ht);
    exp_t e;
    int dx, dy;
    logic [23:0] col;
    @(negedge Clk);
    chk("read_address", 32'(bus.read_address), 32'(m_addr));
    chk("ship_state", 32'(bus.ship_state), 32'(m_state));
    if (sb.size() >= 3) begin
      e = sb.pop_front();
      chk("sprite_on", 32'(bus.sprite_on), 32'(e.on));
      chk("sprite_rgb", 32'(bus.sprite_rgb), 32'(e.rgb));
    end
    bus.frame_start = fs;
    bus.pixel_valid = pv;
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    bus.spawn = sp;
    bus.hit = ht;
    dx = x - m_xl;
    dy = y - m_yl;
    e.on = 1'b0;
    e.rgb = '0;
    if (pv && dx >= 0 && dy >= 0 && dx < 55 && dy < 40) begin
      m_addr = dy * 55 + dx;
      col = ram_fn(19'(m_addr), mode);
      if (m_visible() && col != KEY) begin
        e.on = 1'b1;
        e.rgb = col;
      end
    end
    sb.push_back(e);
    if (sp) m_sp = 1'b1;
    if (ht) m_ht = 1'b1;
    if (fs) begin
      m_xl = int'(bus.ship_x);
      m_yl = int'(bus.ship_y);
      case (m_state)
        0: if (m_sp) m_state = 1;
        1: if (m_ht) begin m_state = 2; m_n = 0; end
        default: begin
          m_n++;
          if (m_n == 64) m_state = 0;
        end
      endcase
      m_sp = 1'b0;
      m_ht = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic sweep(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) step(0, 1, x, y, 0, 0);
    idle(4);
  endtask

  task automatic frame();
    step(1, 0, 0, 0, 0, 0);
    idle(4);
  endtask

  task automatic model_reset();
    sb.delete();
    m_state = 0; m_n = 0; m_xl = 0; m_yl = 0;
    m_addr = 0; m_sp = 0; m_ht = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_sprite_on", 32'(bus.sprite_on), 32'd0);
    chk("rst_sprite_rgb", 32'(bus.sprite_rgb), 32'd0);
    chk("rst_read_address", 32'(bus.read_address), 32'd0);
    chk("rst_ship_state", 32'(bus.ship_state), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    mode = 1'b0;
    bus.frame_start = 0; bus.pixel_valid = 0;
    bus.DrawX = '0; bus.DrawY = '0;
    bus.ship_x = '0; bus.ship_y = '0;
    bus.spawn = 0; bus.hit = 0;
    model_reset();
    Reset_n = 1'b1;
    #1 Reset_n = 1'b0;
    #1 chk_reset_outputs();
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;

    // hidden until spawn; box at origin makes no pixels
    sweep(0, 0, 10);
    frame();
    step(0, 0, 0, 0, 1, 0);
    bus.ship_x = 10'd100;
    bus.ship_y = 10'd50;
    frame();

    // first row, key colour at address 5
    sweep(50, 95, 160);
    sweep(49, 98, 104);
    mode = 1'b1;
    idle(2);
    sweep(51, 98, 160);
    sweep(89, 148, 160);
    sweep(90, 98, 104);

    // mid-frame position change takes effect next frame
    bus.ship_x = 10'd300;
    sweep(50, 95, 160);
    sweep(50, 295, 360);
    frame();
    sweep(50, 95, 110);
    sweep(50, 295, 360);
    sweep(70, 350, 360);

    // mid-line asynchronous reset
    for (int x = 300; x < 310; x++) step(0, 1, x, 50, 0, 0);
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    bus.pixel_valid = 1'b0;
    #1 chk_reset_outputs();
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    sweep(0, 0, 60);
    frame();
    sweep(0, 0, 20);

    // spawn, hit, blink for 64 frames with a stray hit
    bus.ship_x = 10'd100;
    bus.ship_y = 10'd50;
    step(0, 0, 0, 0, 1, 0);
    frame();
    sweep(50, 98, 106);
    step(0, 0, 0, 0, 0, 1);
    frame();
    for (int f = 0; f < 64; f++) begin
      sweep(50, 99, 104);
      if (f == 10) step(0, 0, 0, 0, 0, 1);
      frame();
    end
    sweep(50, 99, 104);
    frame();

    // spawn and hit together while hidden
    step(0, 0, 0, 0, 1, 1);
    frame();
    sweep(50, 99, 104);
    frame();
    sweep(50, 99, 104);

    // hit in the same cycle as frame_start
    step(1, 0, 0, 0, 0, 1);
    idle(4);
    sweep(50, 99, 104);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
